// File: rtl/power_meter_gen.sv
// power_meter_gen: live 0..max ping-pong power meter; a stop edge latches pow_lvl, which is offered with valid/ack.
// Latency: stop edge -> pow_valid 1 cycle; pow_ack -> pow_valid low 1 cycle.
// Backpressure: pow_lvl/pow_valid hold until pow_ack. Optional POWER_TIMEOUT_EN forces a gutter after MAX_SWEEPS.
module power_meter_gen #(
    parameter int LVL_W      = 3,
    parameter int TICK_DIV   = 12500000,
    parameter int MAX_SWEEPS = 3
) (
    input  logic             CLOCK_50,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic             pow_ack,
    output logic [LVL_W-1:0] meter_lvl,
    output logic [LVL_W-1:0] pow_lvl,
    output logic             pow_valid,
    output logic             busy
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(TICK_DIV - 1);
    localparam logic [LVL_W-1:0] LVL_MAX = '1;

    if (TICK_DIV < 1 || MAX_SWEEPS < 1) begin : g_param_check
        $error("power_meter_gen: TICK_DIV and MAX_SWEEPS must be >= 1");
    end

    typedef enum logic [1:0] {
        IDLE,
        SWEEP_UP,
        SWEEP_DOWN,
        HOLD
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [LVL_W-1:0] meter_q, meter_d;
    logic [LVL_W-1:0] pow_lvl_q, pow_lvl_d;
    logic             pow_valid_q, pow_valid_d;
    logic             busy_q, busy_d;
    logic             stop_q, stop_d;
    logic             stop_edge;
    logic [LVL_W-1:0] meter_nxt;

`ifdef POWER_TIMEOUT_EN
    localparam int SW_W = $clog2(MAX_SWEEPS + 1);
    logic [SW_W-1:0] sweep_q, sweep_d;
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        meter_d     = meter_q;
        pow_lvl_d   = pow_lvl_q;
        pow_valid_d = pow_valid_q;
        stop_d      = stop;
        stop_edge   = stop & ~stop_q;
        meter_nxt   = meter_q;
`ifdef POWER_TIMEOUT_EN
        sweep_d     = sweep_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SWEEP_UP;
                    meter_d = '0;
                    cnt_d   = '0;
`ifdef POWER_TIMEOUT_EN
                    sweep_d = '0;
`endif
                end
            end
            SWEEP_UP, SWEEP_DOWN: begin
                if (stop_edge) begin
                    // Latch the value shown before any step in this same cycle.
                    pow_lvl_d   = meter_q;
                    pow_valid_d = 1'b1;
                    state_d     = HOLD;
                    cnt_d       = '0;
                end else if (cnt_q == CNT_TOP) begin
                    cnt_d = '0;
                    if (state_q == SWEEP_UP) begin
                        meter_nxt = (meter_q == LVL_MAX) ? meter_q : meter_q + 1'b1;
                        meter_d   = meter_nxt;
                        if (meter_nxt == LVL_MAX) state_d = SWEEP_DOWN;
                    end else begin
                        meter_nxt = (meter_q == '0) ? meter_q : meter_q - 1'b1;
                        meter_d   = meter_nxt;
                        if (meter_nxt == '0) begin
                            state_d = SWEEP_UP;
`ifdef POWER_TIMEOUT_EN
                            sweep_d = sweep_q + 1'b1;
                            if (sweep_d == SW_W'(MAX_SWEEPS)) begin
                                state_d     = HOLD;
                                pow_lvl_d   = '0;
                                pow_valid_d = 1'b1;
                            end
`endif
                        end
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            HOLD: begin
                if (pow_ack) begin
                    state_d     = IDLE;
                    pow_valid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            meter_q     <= '0;
            pow_lvl_q   <= '0;
            pow_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            stop_q      <= 1'b0;
`ifdef POWER_TIMEOUT_EN
            sweep_q     <= '0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            meter_q     <= meter_d;
            pow_lvl_q   <= pow_lvl_d;
            pow_valid_q <= pow_valid_d;
            busy_q      <= busy_d;
            stop_q      <= stop_d;
`ifdef POWER_TIMEOUT_EN
            sweep_q     <= sweep_d;
`endif
        end
    end

    assign meter_lvl = meter_q;
    assign pow_lvl   = pow_lvl_q;
    assign pow_valid = pow_valid_q;
    assign busy      = busy_q;

endmodule
